// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first.
// Start accepted in IDLE or DONE; done pulses WIDTH cycles later.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [IW-1:0]    idx_q;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic             co_q;
  logic             ov_q;

  logic in1;
  logic in2;
  logic sum_d;
  logic cout_d;
  logic last;

  // The single full-adder slice.
  assign in1    = a_q[idx_q];
  assign in2    = b_q[idx_q];
  assign sum_d  = in1 ^ in2 ^ c_q;
  assign cout_d = (in1 & in2) | (c_q & (in1 ^ in2));
  assign last   = (idx_q == IW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      co_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b ^ {WIDTH{sub}};
            c_q     <= sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          result_q[idx_q] <= sum_d;
          c_q             <= cout_d;
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            co_q    <= cout_d;
            // c_q is the carry into the MSB on this edge.
            ov_q    <= c_q ^ cout_d;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed table, corner sequences,
// and an exhaustive sweep over a bank of lock-stepped instances.
module tb_serial_adder_ctrl;

  localparam int NL = 64;
  localparam int NP = 131072;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] r;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] r;
    logic       co;
    logic       ov;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       overflow;

  logic          lstart;
  logic          lsub [NL];
  logic [7:0]    la   [NL];
  logic [7:0]    lb   [NL];
  logic [7:0]    lres [NL];
  logic [NL-1:0] lbusy;
  logic [NL-1:0] ldone;
  logic [NL-1:0] lco;
  logic [NL-1:0] lov;

  int   checks;
  int   errors;
  exp_t sbq [$];
  vec_t tbl [10];

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done),
    .result(result),
    .carry_out(carry_out),
    .overflow(overflow)
  );

  for (genvar g = 0; g < NL; g++) begin : g_lane
    serial_adder_ctrl #(.WIDTH(8)) u (
      .clk(clk), .rst_n(rst_n),
      .start(lstart), .sub(lsub[g]),
      .op_a(la[g]), .op_b(lb[g]),
      .busy(lbusy[g]), .done(ldone[g]),
      .result(lres[g]),
      .carry_out(lco[g]),
      .overflow(lov[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t ref_op(input logic [7:0] a,
                                  input logic [7:0] b,
                                  input logic s);
    exp_t e;
    logic [8:0] f;
    if (s) f = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else   f = {1'b0, a} + {1'b0, b};
    e.r  = f[7:0];
    e.co = f[8];
    if (s) e.ov = (a[7] != b[7]) && (e.r[7] != a[7]);
    else   e.ov = (a[7] == b[7]) && (e.r[7] != a[7]);
    return e;
  endfunction

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({nm, " sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({nm, " result"}, {24'd0, result}, {24'd0, e.r});
      chk({nm, " carry"}, {31'd0, carry_out}, {31'd0, e.co});
      chk({nm, " ovf"}, {31'd0, overflow}, {31'd0, e.ov});
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b,
                    input logic s, input exp_t e, input string nm);
    int cyc;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op_a = ~a; op_b = a ^ b; sub = ~s;
    chk({nm, " busy"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, cyc, 32'd8);
    chk({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
    if (done) pop_cmp(nm);
    else void'(sbq.pop_front());
    @(negedge clk);
    chk({nm, " done_fall"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int seen;
    exp_t e;
    logic [16:0] p;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0;
    op_a = '0; op_b = '0; lstart = 1'b0;
    for (int i = 0; i < NL; i++) begin
      lsub[i] = 1'b0; la[i] = '0; lb[i] = '0;
    end
    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{8'hA5, 8'h5A, 1'b1, 8'h4B, 1'b1, 1'b1};
    tbl[8] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[9] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", {24'd0, result}, 32'd0);
    chk("rst carry", {31'd0, carry_out}, 32'd0);
    chk("rst ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e.r = tbl[i].r; e.co = tbl[i].co; e.ov = tbl[i].ov;
      op(tbl[i].a, tbl[i].b, tbl[i].s, e,
         $sformatf("vec%0d", i));
    end

    op_a = 8'hFF; op_b = 8'hFF; sub = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold result", {24'd0, result}, {24'd0, tbl[9].r});
    chk("hold ovf", {31'd0, overflow}, {31'd0, tbl[9].ov});

    // Back-to-back: start held, operands changed mid-run.
    @(negedge clk);
    start = 1'b1; op_a = 8'h11; op_b = 8'h22; sub = 1'b0;
    sbq.push_back(ref_op(8'h11, 8'h22, 1'b0));
    @(posedge clk);
    @(negedge clk);
    op_a = 8'h40; op_b = 8'h03;
    chk("b2b busy", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b first latency", cyc, 32'd8);
    pop_cmp("b2b first");
    sbq.push_back(ref_op(8'h40, 8'h03, 1'b0));
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("b2b rearm busy", {31'd0, busy}, 32'd1);
      end
      if (done) break;
    end
    chk("b2b gap", cyc, 32'd9);
    pop_cmp("b2b second");
    @(negedge clk);
    chk("b2b end done", {31'd0, done}, 32'd0);
    chk("b2b end busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; op_a = 8'h0F; op_b = 8'h00; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst result", {24'd0, result}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    chk("arst carry", {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("arst no done", seen, 32'd0);
    op(8'h12, 8'h34, 1'b0, ref_op(8'h12, 8'h34, 1'b0), "post_rst");

    // Exhaustive sweep, NL pairs per round.
    for (int r = 0; r < NP / NL; r++) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
        p = 17'(r * NL + i);
        lsub[i] = p[16]; la[i] = p[15:8]; lb[i] = p[7:0];
        sbq.push_back(ref_op(p[15:8], p[7:0], p[16]));
      end
      lstart = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lstart = 1'b0;
      cyc = 0;
      while (ldone != {NL{1'b1}} && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      if (ldone != {NL{1'b1}})
        chk($sformatf("sweep r%0d timeout", r), {{(32-NL>0?0:0){1'b0}}, 32'(ldone != {NL{1'b1}})}, 32'd0);
      for (int i = 0; i < NL; i++) begin
        e = sbq.pop_front();
        p = 17'(r * NL + i);
        chk($sformatf("sweep s%0d a%02h b%02h", p[16], p[15:8], p[7:0]),
            {22'd0, lres[i], lco[i], lov[i]},
            {22'd0, e.r, e.co, e.ov});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 SHALL have port sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL have port op_a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port op_b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  WIDTH  sum/difference, held until next accepted start.
REQ-011 SHALL have port carry_out  output  1  final carry (sub: 1 = no borrow).
REQ-012 SHALL have port overflow  output  1  signed (two's-complement) overflow of the last operation.

Function
REQ-013 SHALL compute using exactly one 1-bit full-adder slice (in1, in2, carryIn -> sum, carryOut), one bit per cycle, LSB first; no WIDTH-bit adder.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: start=1 SHALL latch op_a, op_b XOR {WIDTH{sub}}, carry register = sub, bit index = 0, go RUN, busy=1 from that edge.
REQ-016 RUN: each cycle SHALL feed slice with a[idx], b'[idx], carry reg; store sum into result[idx], carry reg <= slice carryOut, idx <= idx+1.
REQ-017 RUN: on edge processing idx = WIDTH-1 SHALL go DONE, busy=0, done=1, carry_out = slice carryOut, overflow = carry into MSB XOR carry out of MSB.
REQ-018 Latency: start accepted at edge k -> done high for exactly the cycle after edge k+WIDTH; busy high during cycles k..k+WIDTH-1.
REQ-019 DONE: done SHALL fall after one cycle; state returns to IDLE unless start=1, in which case new operation accepted exactly as REQ-015 (back-to-back, no idle gap).
REQ-020 start while in RUN SHALL be ignored; latched operands and sub SHALL not change mid-operation.
REQ-021 op_a/op_b/sub changes outside an accepting edge SHALL not affect result.
REQ-022 result, carry_out, overflow SHALL keep last completed values in IDLE; result bits SHALL update progressively during RUN (not valid until done).
REQ-023 Bit index SHALL be ceil(log2(WIDTH)) bits wide and never wrap past WIDTH-1 within an operation.

Reset
REQ-024 rst_n=0 SHALL immediately, without clk, force state IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, carry reg=0, idx=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-026 After rst_n rises, first start sampled on a subsequent rising clk SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 Bench SHALL cover: start, A=0x00, B=0x00, sub=0 -> done 8 cycles after accept edge, result=0x00, carry_out=0, overflow=0.
REQ-028 Bench SHALL cover: A=0xFF, B=0x01, sub=0 -> result=0x00, carry_out=1, overflow=0; A=0x7F, B=0x01 -> result=0x80, carry_out=0, overflow=1.
REQ-029 Bench SHALL cover: A=0x05, B=0x07, sub=1 -> result=0xFE, carry_out=0; A=0x80, B=0x01, sub=1 -> result=0x7F, overflow=1.
REQ-030 Bench SHALL cover: start held high and operands changed during RUN -> single done for first operands; start high in DONE cycle -> second operation begins, done exactly 9 cycles after first done.
REQ-031 Bench SHALL cover: rst_n pulsed low at RUN cycle 4 -> busy=0, result=0 asynchronously, no done afterward; next start 0x12+0x34 -> 0x46.
REQ-032 Bench SHALL exhaustively compare all 65536 A/B pairs for sub=0 and sub=1 against reference arithmetic.
